apb_txn_arbiter: RTL and testbench

- Shares one APB master port between NUM_REQ on-chip requesters (AHB-to-APB bridge, DMA, debug port).
- Round-robin arbitration picks one request per transfer. The block decodes the address to the GPIO or SPI slave and runs the APB SETUP/ACCESS sequence.
- A timeout counter bounds every transfer. The result goes back to the granted requester with a one-cycle done pulse.
- Sits in the peripheral subsystem between the bridge/DMA request side and the apb_gpio/apb_spi slaves.

---
 rtl/apb_txn_arbiter_pkg.sv | 42 ++++
 rtl/apb_txn_arbiter_rr.sv | 42 ++++
 rtl/apb_txn_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_txn_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_txn_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_txn_arbiter_pkg
// Shared definitions for the APB transaction arbiter: slave address windows,
// the transfer state machine encoding, the slave-select encoding and the
// address decoder used to route a granted request to GPIO or SPI.
// -----------------------------------------------------------------------------
package apb_txn_arbiter_pkg;

  // Inclusive address windows of the two APB slaves.
  localparam logic [63:0] GPIO_LOW  = 64'h0000_0000;
  localparam logic [63:0] GPIO_HIGH = 64'h0000_0020;
  localparam logic [63:0] SPI_LOW   = 64'h0000_0100;
  localparam logic [63:0] SPI_HIGH  = 64'h0000_011C;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    SLV_NONE,
    SLV_GPIO,
    SLV_SPI
  } slave_e;

  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] lo,
                                    input logic [63:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

  // Addresses are zero-extended to 64 bits by the caller so the decoder
  // works for any ADDR_W up to 64; upper address bits must be zero to hit.
  function automatic slave_e decode_addr(input logic [63:0] addr);
    if (in_range(addr, GPIO_LOW, GPIO_HIGH)) return SLV_GPIO;
    if (in_range(addr, SPI_LOW, SPI_HIGH))   return SLV_SPI;
    return SLV_NONE;
  endfunction

endpackage

// File: rtl/apb_txn_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches from (last_i + 1) mod NUM_REQ
// upward and returns the first active request.
//   req_i        : active requests
//   last_i       : index of the most recently served requester
//   grant_vec_o  : one-hot winner (all zero when no request)
//   index_o      : binary index of the winner
//   valid_o      : at least one request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] grant_vec_o,
  output logic [IDX_W-1:0]   index_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant_vec_o = '0;
    index_o     = '0;
    valid_o     = 1'b0;
    cand        = '0;
    // Offset 1 first so the requester just served is tried last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o           = 1'b1;
        index_o           = cand;
        grant_vec_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_txn_arbiter.sv
// -----------------------------------------------------------------------------
// apb_txn_arbiter
// Shares one APB master port between NUM_REQ requesters. A round-robin pick
// grants one request per transfer, the latched address is routed to the GPIO
// or SPI slave, and a SETUP/ACCESS sequence is run with a bounded wait. The
// result returns to the granted requester with a one-cycle done pulse.
//   apb_clk, rst_n          : clock, asynchronous reset (active HIGH)
//   req/req_addr/req_write/
//   req_wdata/req_prot      : packed per-requester transfer requests
//   grant, done             : one-hot pulses to the requesters
//   rsp_rdata, rsp_err      : response, valid while done is high
//   paddr..penable, psel_*  : APB master side
//   prdata_*, pready,
//   pslverr                 : APB slave responses
// -----------------------------------------------------------------------------
module apb_txn_arbiter
  import apb_txn_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      apb_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*3-1:0]      req_prot,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [2:0]                pprot,
  output logic [3:0]                pstrb,
  output logic                      penable,
  output logic                      psel_gpio,
  output logic                      psel_spi,
  input  logic [DATA_W-1:0]         prdata_gpio,
  input  logic [DATA_W-1:0]         prdata_spi,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  slave_e             slv_q, slv_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [2:0]         pprot_q, pprot_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [ADDR_W-1:0]  sel_addr;
  slave_e             sel_slv;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i       (req),
    .last_i      (last_q),
    .grant_vec_o (arb_grant),
    .index_o     (arb_idx),
    .valid_o     (arb_valid)
  );

  assign sel_addr = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
  // Decoding the incoming address is equivalent to decoding the latched copy
  // and lets a miss reach RESP one cycle after the grant.
  assign sel_slv  = decode_addr(64'(sel_addr));

  always_comb begin
    state_d  = state_q;
    slv_d    = slv_q;
    g_d      = g_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          g_d      = arb_idx;
          slv_d    = sel_slv;
          paddr_d  = sel_addr;
          pwrite_d = req_write[arb_idx];
          pwdata_d = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
          pprot_d  = req_prot[int'(arb_idx)*3 +: 3];
          cnt_d    = '0;
          if (sel_slv == SLV_NONE) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end

      SETUP: state_d = ACCESS;

      ACCESS: begin
        if (pready) begin
          rdata_d = pwrite_q ? '0 : ((slv_q == SLV_SPI) ? prdata_spi : prdata_gpio);
          err_d   = pslverr;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        last_d  = g_q;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // rst_n is active HIGH on this block despite its name.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge apb_clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      slv_q    <= SLV_NONE;
      g_q      <= '0;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slv_q    <= slv_d;
      g_q      <= g_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Grant is combinational from the arbiter, so it is masked while reset is
  // held to keep every output quiet during reset.
  assign grant     = (state_q == IDLE && !rst_n) ? arb_grant : '0;
  assign done      = (state_q == RESP) ? (NUM_REQ'(1) << g_q) : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign pprot     = pprot_q;
  assign pstrb     = 4'hF;
  assign penable   = (state_q == ACCESS);
  assign psel_gpio = (state_q == SETUP || state_q == ACCESS) && (slv_q == SLV_GPIO);
  assign psel_spi  = (state_q == SETUP || state_q == ACCESS) && (slv_q == SLV_SPI);

endmodule

// File: tb/tb_apb_txn_arbiter.sv
module tb_apb_txn_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            apb_clk;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_write;
  logic [NR*DW-1:0] req_wdata;
  logic [NR*3-1:0] req_prot;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   paddr;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [2:0]      pprot;
  logic [3:0]      pstrb;
  logic            penable;
  logic            psel_gpio;
  logic            psel_spi;
  logic [DW-1:0]   prdata_gpio;
  logic [DW-1:0]   prdata_spi;
  logic            pready;
  logic            pslverr;

  int n_checks;
  int n_fail;

  apb_txn_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (16)
  ) dut (
    .apb_clk     (apb_clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .req_prot    (req_prot),
    .grant       (grant),
    .done        (done),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pprot       (pprot),
    .pstrb       (pstrb),
    .penable     (penable),
    .psel_gpio   (psel_gpio),
    .psel_spi    (psel_spi),
    .prdata_gpio (prdata_gpio),
    .prdata_spi  (prdata_spi),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial apb_clk = 1'b0;
  always #5 apb_clk = ~apb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One single-requester transfer and its hand-computed outcome.
  // waits = number of ACCESS cycles with pready low before pready rises;
  // a value >= 16 never raises pready. sel = {psel_gpio, psel_spi, penable}
  // expected in the SETUP cycle. done_t = cycles from grant to done.
  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    logic [31:0] prd_gpio;
    logic [31:0] prd_spi;
    int          waits;
    logic        slverr;
    int          done_t;
    logic [2:0]  sel;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name, input int exp_idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge apb_clk);
      if (grant != '0) seen = 1'b1;
    end
    check(name, grant, 64'(3'b001 << exp_idx));
  endtask

  task automatic wait_done(input string name, input int exp_idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge apb_clk);
      if (done != '0) seen = 1'b1;
    end
    check(name, done, 64'(3'b001 << exp_idx));
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int acc;
    int t;
    bit seen;
    @(posedge apb_clk); #1;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = 32'hFFFF_FFF0;
      req_wdata[i*DW +: DW] = 32'h5555_5555;
      req_prot[i*3 +: 3]    = 3'd5;
    end
    req_write              = '1;
    req_addr[v.id*AW +: AW]  = v.addr;
    req_wdata[v.id*DW +: DW] = v.wdata;
    req_prot[v.id*3 +: 3]    = v.prot;
    req_write[v.id]          = v.wr;
    prdata_gpio = v.prd_gpio;
    prdata_spi  = v.prd_spi;
    pslverr     = v.slverr;
    pready      = 1'b0;
    req         = '0;
    req[v.id]   = 1'b1;
    @(negedge apb_clk);
    check($sformatf("v%0d grant", k), grant, 64'(3'b001 << v.id));
    // Drop the request and scramble its fields right after the grant edge.
    @(posedge apb_clk); #1;
    req = '0;
    req_addr[v.id*AW +: AW]  = 32'h0000_0008;
    req_wdata[v.id*DW +: DW] = ~v.wdata;
    acc  = 0;
    t    = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge apb_clk);
      if (c == 1) begin
        check($sformatf("v%0d setup sel", k), {psel_gpio, psel_spi, penable}, 64'(v.sel));
        if (v.sel != 3'b000) begin
          check($sformatf("v%0d paddr", k), paddr, 64'(v.addr));
          check($sformatf("v%0d pwdata", k), pwdata, 64'(v.wdata));
          check($sformatf("v%0d pwrite/pprot", k), {pwrite, pprot}, 64'({v.wr, v.prot}));
        end
      end
      if (c == 2 && v.sel != 3'b000)
        check($sformatf("v%0d access sel", k), {psel_gpio, psel_spi, penable}, 64'(v.sel | 3'b001));
      if (done != '0) begin
        seen = 1'b1;
        t    = c;
      end else if (penable) begin
        acc++;
        pready = (acc == v.waits + 1);
      end else begin
        pready = 1'b0;
      end
    end
    pready = 1'b0;
    check($sformatf("v%0d done cycle", k), 64'(t), 64'(v.done_t));
    check($sformatf("v%0d done vec", k), done, 64'(3'b001 << v.id));
    check($sformatf("v%0d rsp_err", k), rsp_err, 64'(v.err));
    check($sformatf("v%0d rsp_rdata", k), rsp_rdata, 64'(v.rdata));
    check($sformatf("v%0d bus idle at done", k), {psel_gpio, psel_spi, penable}, 64'(0));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    req         = '1;
    req_addr    = {3{32'h0000_0010}};
    req_write   = '0;
    req_wdata   = '0;
    req_prot    = '0;
    prdata_gpio = '0;
    prdata_spi  = '0;
    pready      = 1'b0;
    pslverr     = 1'b0;

    //          id addr            wr wdata          prot prd_gpio       prd_spi        wt  se dt sel     err rdata
    vecs[0]  = '{0, 32'h0000_0010, 1, 32'hA5A5_0001, 3'd0, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 0,  0, 3,  3'b100, 0, 32'h0};
    vecs[1]  = '{1, 32'h0000_0104, 0, 32'h0000_0000, 3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 3,  0, 6,  3'b010, 0, 32'h1234_5678};
    vecs[2]  = '{2, 32'h0000_0020, 0, 32'h0000_0000, 3'd1, 32'hCAFE_0001, 32'h0BAD_0BAD, 0,  0, 3,  3'b100, 0, 32'hCAFE_0001};
    vecs[3]  = '{0, 32'h0000_0000, 0, 32'h0000_0000, 3'd0, 32'h1111_1111, 32'h2222_2222, 99, 0, 18, 3'b100, 1, 32'h0};
    vecs[4]  = '{1, 32'h0000_0200, 0, 32'h0000_0000, 3'd0, 32'h1111_1111, 32'h2222_2222, 0,  0, 1,  3'b000, 1, 32'h0};
    vecs[5]  = '{2, 32'h0000_0104, 0, 32'h0000_0000, 3'd7, 32'h0000_0001, 32'h0000_0055, 0,  1, 3,  3'b010, 1, 32'h0000_0055};
    vecs[6]  = '{0, 32'h0000_011C, 1, 32'h0F0F_F0F0, 3'd3, 32'h0000_0001, 32'h0000_0002, 1,  0, 4,  3'b010, 0, 32'h0};
    vecs[7]  = '{1, 32'h0000_0021, 0, 32'h0000_0000, 3'd0, 32'h1111_1111, 32'h2222_2222, 0,  0, 1,  3'b000, 1, 32'h0};
    vecs[8]  = '{2, 32'h0000_00FC, 0, 32'h0000_0000, 3'd0, 32'h1111_1111, 32'h2222_2222, 0,  0, 1,  3'b000, 1, 32'h0};
    vecs[9]  = '{0, 32'h0000_0120, 0, 32'h0000_0000, 3'd0, 32'h1111_1111, 32'h2222_2222, 0,  0, 1,  3'b000, 1, 32'h0};
    vecs[10] = '{0, 32'h0000_0004, 0, 32'h0000_0000, 3'd4, 32'h7777_0004, 32'h2222_2222, 15, 0, 18, 3'b100, 0, 32'h7777_0004};
    vecs[11] = '{1, 32'h8000_0010, 0, 32'h0000_0000, 3'd0, 32'h1111_1111, 32'h2222_2222, 0,  0, 1,  3'b000, 1, 32'h0};

    // Reset state, with requests asserted to show grant stays quiet.
    repeat (3) @(posedge apb_clk);
    @(negedge apb_clk);
    check("reset grant", grant, 64'(0));
    check("reset done", done, 64'(0));
    check("reset bus ctrl", {psel_gpio, psel_spi, penable}, 64'(0));
    check("reset paddr", paddr, 64'(0));
    check("reset pwdata", pwdata, 64'(0));
    check("reset pwrite/pprot", {pwrite, pprot}, 64'(0));
    check("reset rsp", {rsp_err, rsp_rdata}, 64'(0));
    check("pstrb", pstrb, 64'(4'hF));
    @(posedge apb_clk); #1;
    req   = '0;
    rst_n = 1'b0;

    foreach (vecs[k]) run_vec(k, vecs[k]);

    // Contention: all requesters held, fresh reset so requester 0 leads.
    @(posedge apb_clk); #1;
    rst_n = 1'b1;
    @(posedge apb_clk); #1;
    rst_n       = 1'b0;
    req_addr    = {3{32'h0000_0010}};
    req_write   = '0;
    pslverr     = 1'b0;
    pready      = 1'b1;
    req         = 3'b111;
    wait_grant("rr grant 1st", 0);
    wait_grant("rr grant 2nd", 1);
    wait_grant("rr grant 3rd", 2);
    wait_grant("rr grant 4th", 0);
    wait_grant("rr grant 5th", 1);
    req = 3'b011;
    wait_grant("rr after 1 served", 0);
    @(posedge apb_clk); #1;
    req = '0;
    wait_done("rr final done", 0);

    // Reset during ACCESS of a SPI transfer from requester 1.
    pready = 1'b0;
    req_addr[1*AW +: AW] = 32'h0000_0104;
    req = 3'b010;
    wait_grant("pre-reset grant", 1);
    @(negedge apb_clk);
    @(negedge apb_clk);
    check("pre-reset penable", {psel_gpio, psel_spi, penable}, 64'(3'b011));
    #2;
    rst_n = 1'b1;
    #1;
    check("async reset bus ctrl", {psel_gpio, psel_spi, penable}, 64'(0));
    check("async reset done", done, 64'(0));
    req = 3'b011;
    #1;
    check("grant held in reset", grant, 64'(0));
    pready = 1'b1;
    @(posedge apb_clk); #1;
    rst_n = 1'b0;
    wait_grant("post-reset grant", 0);
    @(posedge apb_clk); #1;
    req = '0;
    wait_done("post-reset done", 0);
    pready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
